// File: rtl/divider_pkg.sv
// Shared execute-stage definitions: multiply/divide op encoding and divider FSM states.
// The multiplier imports the same op constants so the EX stall logic can treat both units alike.
package divider_pkg;

    localparam logic [1:0] OP_NONE     = 2'b00;
    localparam logic [1:0] OP_UNSIGNED = 2'b01;
    localparam logic [1:0] OP_SIGNED   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Divider request/result bundle: op/a/b towards the unit, q/r/done back to the execute stage.
// done doubles as ready (idle) and result-valid.
interface divider_if #(parameter int WIDTH = 32);
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             done;

    modport master (output op, a, b, input q, r, done);
    modport slave  (input op, a, b, output q, r, done);
endinterface

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: magnitudes in, sign fix-up at the end.
// Latency: 34 busy cycles from accept edge; op is ignored (not queued) while done is low.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      resetn,
    divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state, state_nx;
    logic [CW-1:0]    cnt;
    logic             setup;
    logic [WIDTH-1:0] rem, dvd, dvs, quot, araw, q, r;
    logic             qs, rs, bz;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff, rem_nx;
    logic             qbit, accept, sgn;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        sgn      = (bus.op == OP_SIGNED);
        accept   = (state == IDLE) && ((bus.op == OP_SIGNED) || (bus.op == OP_UNSIGNED));
        rem_sh   = {rem, dvd[WIDTH-1]};
        qbit     = (rem_sh >= {1'b0, dvs});
        // rem_sh < 2*dvs, so when qbit is set the difference always fits in WIDTH bits
        diff     = rem_sh[WIDTH-1:0] - dvs;
        rem_nx   = qbit ? diff : rem_sh[WIDTH-1:0];
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (!setup && cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            setup <= 1'b0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            quot  <= '0;
            araw  <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            bz    <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    dvd   <= mag(bus.a, sgn && bus.a[WIDTH-1]);
                    dvs   <= mag(bus.b, sgn && bus.b[WIDTH-1]);
                    qs    <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rs    <= sgn && bus.a[WIDTH-1];
                    bz    <= (bus.b == '0);
                    araw  <= bus.a;
                    rem   <= '0;
                    quot  <= '0;
                    cnt   <= CW'(WIDTH - 1);
                    setup <= 1'b1;
                end
                CALC: begin
                    // one alignment cycle before the first quotient bit keeps the
                    // busy window at 34 cycles, matching the multiplier stall timing
                    if (setup) begin
                        setup <= 1'b0;
                    end else begin
                        rem  <= rem_nx;
                        dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        quot <= {quot[WIDTH-2:0], qbit};
                        cnt  <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    q <= bz ? '1   : (qs ? -quot : quot);
                    r <= bz ? araw : (rs ? -rem  : rem);
                end
                default: ;
            endcase
        end
    end

    assign bus.q    = q;
    assign bus.r    = r;
    assign bus.done = (state == IDLE);

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected q/r, a monitor pops on each done rise.
module tb_divider;
    import divider_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } exp_t;
    exp_t sb[$];

    divider_if bus();
    divider dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    // Monitor: on every done rise compare against the oldest expectation and the busy length.
    logic prev_done = 1'b1;
    int   busy = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_done <= 1'b1;
            busy      <= 0;
        end else begin
            prev_done <= bus.done;
            if (!bus.done) busy <= busy + 1;
            if (!prev_done && bus.done) begin
                exp_t e;
                busy <= 0;
                checks++;
                if (busy != 34) begin
                    errors++;
                    $display("FAIL latency: busy %0d cycles, expected 34", busy);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected result: q=%h r=%h", bus.q, bus.r);
                end else begin
                    e = sb.pop_front();
                    if (bus.q !== e.q || bus.r !== e.r) begin
                        errors++;
                        $display("FAIL %s: got q=%h r=%h, expected q=%h r=%h",
                                 e.name, bus.q, bus.r, e.q, e.r);
                    end
                end
            end
        end
    end

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == OP_SIGNED) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = sa / sb_;
                r = sa % sb_;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Starts and ends aligned to a falling edge; ends on the first cycle done is high again.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input bit garble);
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL %s: timeout waiting for idle", name);
        end
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        sb.push_back('{q: eq, r: er, name: name});
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: done=%b, expected 0", name, bus.done);
        end
        n = 0;
        while (!bus.done && n < 200) begin
            if (garble) begin
                bus.op = 2'($urandom_range(1, 2));
                bus.a  = $urandom;
                bus.b  = $urandom;
            end else begin
                bus.op = OP_NONE;
            end
            @(negedge clk);
            n++;
        end
        bus.op = OP_NONE;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s: timeout waiting for result", name);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, rq, rr;
        int          n;
        bus.op = OP_NONE;
        bus.a  = '0;
        bus.b  = '0;
        #12;
        check_val("reset done", {31'd0, bus.done}, 32'd1);
        check_val("reset q", bus.q, 32'd0);
        check_val("reset r", bus.r, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        issue("u 100/7",         OP_UNSIGNED, 32'd100,       32'd7,         32'd14,        32'd2,         0);
        issue("s -7/2",          OP_SIGNED,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        issue("s 7/-2",          OP_SIGNED,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0);
        issue("u ffffffff/2",    OP_UNSIGNED, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1,         0);
        issue("s overflow",      OP_SIGNED,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
        issue("u 5/0",           OP_UNSIGNED, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         0);
        issue("s -5/0",          OP_SIGNED,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
        issue("u max/max",       OP_UNSIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         0);
        issue("u 3/10",          OP_UNSIGNED, 32'd3,         32'd10,        32'd0,         32'd3,         0);
        issue("s min/2",         OP_SIGNED,   32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         0);
        issue("s -100/-7",       OP_SIGNED,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 0);
        issue("s 100/-7 garble", OP_SIGNED,   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1);

        // op=11 in idle must not start anything
        bus.op = 2'b11;
        bus.a  = 32'd50;
        bus.b  = 32'd3;
        @(negedge clk);
        @(negedge clk);
        bus.op = OP_NONE;
        check_val("op11 done", {31'd0, bus.done}, 32'd1);
        check_val("op11 q", bus.q, 32'hFFFF_FFF2);
        check_val("op11 r", bus.r, 32'd2);

        // asynchronous reset part-way through a calculation
        bus.op = OP_UNSIGNED;
        bus.a  = 32'd77;
        bus.b  = 32'd5;
        @(negedge clk);
        bus.op = OP_NONE;
        repeat (10) @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        check_val("abort done", {31'd0, bus.done}, 32'd1);
        check_val("abort q", bus.q, 32'd0);
        check_val("abort r", bus.r, 32'd0);
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        issue("u 1000/10 after reset", OP_UNSIGNED, 32'd1000, 32'd10, 32'd100, 32'd0, 0);

        // back-to-back: second op presented on the very first idle cycle
        issue("b2b u 9/4",  OP_UNSIGNED, 32'd9,         32'd4, 32'd2,         32'd1,         0);
        issue("b2b s -9/4", OP_SIGNED,   32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(1, 2));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 7 == 0) rb = -rb;
            model(rop, ra, rb, rq, rr);
            issue("random", rop, ra, rb, rq, rr, 0);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
